// File: rtl/pixel_map_pkg.sv
// pixel_map_pkg: shared FSM state type, coefficient indices and width helpers for pixel_map_stream.
package pixel_map_pkg;

    typedef enum logic [2:0] {IDLE, MUL, SIGN, DIV, DONE} state_e;

    localparam int N_COEF = 9;
    localparam int P1_IDX = 0;
    localparam int P2_IDX = 1;
    localparam int P3_IDX = 2;
    localparam int P4_IDX = 3;
    localparam int P5_IDX = 4;
    localparam int P6_IDX = 5;
    localparam int P7_IDX = 6;
    localparam int P8_IDX = 7;
    localparam int P9_IDX = 8;

    function automatic int acc_w(input int p_w, input int x_w, input int y_w);
        return p_w + ((x_w > y_w) ? x_w : y_w) + 2;
    endfunction

    function automatic int q_w(input int ox_w, input int oy_w);
        return ((ox_w > oy_w) ? ox_w : oy_w) + 1;
    endfunction

endpackage

// File: rtl/pixel_map_div.sv
// pixel_map_div: serial restoring unsigned divider, one quotient bit per cycle over Q_W cycles.
module pixel_map_div #(
    parameter int ACC_W = 40,
    parameter int Q_W   = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [ACC_W-1:0] dividend,
    input  logic [ACC_W-1:0] divisor,
    output logic [Q_W-1:0]   quotient,
    output logic             done
);

    localparam int CW = $clog2(Q_W);

    logic [ACC_W+Q_W-1:0] dsh_q, dsh_d;
    logic [ACC_W-1:0]     rem_q, rem_d;
    logic [Q_W-1:0]       quo_q, quo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 fit;

    // The caller guarantees dividend < divisor*2^Q_W, so the divisor starts at bit Q_W-1.
    always_comb begin
        fit    = {{Q_W{1'b0}}, rem_q} >= dsh_q;
        done   = busy_q && cnt_q == CW'(Q_W - 1);
        dsh_d  = dsh_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            rem_d  = dividend;
            dsh_d  = {1'b0, divisor, {(Q_W-1){1'b0}}};
            quo_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = fit ? rem_q - dsh_q[ACC_W-1:0] : rem_q;
            quo_d  = {quo_q[Q_W-2:0], fit};
            dsh_d  = dsh_q >> 1;
            cnt_d  = cnt_q + CW'(1);
            busy_d = !done;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dsh_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            dsh_q  <= dsh_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/pixel_map_stream.sv
// pixel_map_stream: handshaked projective pixel mapper with double-buffered 3x3 homography.
// Define HMAP_CLAMP_EN to saturate out-of-range axes instead of zeroing both outputs.
module pixel_map_stream
    import pixel_map_pkg::*;
#(
    parameter int X_W  = 10,
    parameter int Y_W  = 9,
    parameter int OX_W = 10,
    parameter int OY_W = 9,
    parameter int P_W  = 28
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  coef_we,
    input  logic [3:0]            coef_addr,
    input  logic signed [P_W-1:0] coef_data,
    input  logic                  coef_commit,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [X_W-1:0]        x,
    input  logic [Y_W-1:0]        y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OX_W-1:0]       ox,
    output logic [OY_W-1:0]       oy,
    output logic                  oob
);

    localparam int ACC_W = acc_w(P_W, X_W, Y_W);
    localparam int Q_W   = q_w(OX_W, OY_W);

    state_e                  state_q, state_d;
    logic signed [P_W-1:0]   shd_q [N_COEF];
    logic signed [P_W-1:0]   act_q [N_COEF];
    logic                    pend_q, accept, copy, start, done_x, done_y;
    logic [X_W-1:0]          x_q;
    logic [Y_W-1:0]          y_q;
    logic signed [ACC_W-1:0] xs, ys, nx_q, ny_q, d_q, nx_d, ny_d, d_d;
    logic [ACC_W-1:0]        ab_x, ab_y, ab_d;
    logic                    sx_q, sy_q, ovx_q, ovy_q, dz_q;
    logic [Q_W-1:0]          qx, qy;
    logic                    neg_x, neg_y, big_x, big_y, oob_v;
    logic [OX_W-1:0]         vx;
    logic [OY_W-1:0]         vy;

    function automatic logic signed [ACC_W-1:0] cx(input logic signed [P_W-1:0] p);
        return ACC_W'(p);
    endfunction

    function automatic logic signed [P_W-1:0] ident(input int i);
        return (i == P1_IDX || i == P5_IDX || i == P9_IDX) ? P_W'(1) : '0;
    endfunction

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign accept    = in_valid && in_ready;
    // The bank swap waits for an idle cycle so an in-flight pixel never sees mixed coefficients.
    assign copy      = state_q == IDLE && !accept && pend_q;
    assign start     = state_q == SIGN && d_q != '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? MUL : IDLE;
            MUL:     state_d = SIGN;
            SIGN:    state_d = (d_q == '0) ? DONE : DIV;
            DIV:     state_d = (done_x && done_y) ? DONE : DIV;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        state_q <= reset ? IDLE : state_d;
    end

    always_comb begin
        xs   = signed'(ACC_W'(x_q));
        ys   = signed'(ACC_W'(y_q));
        nx_d = cx(act_q[P1_IDX]) * xs + cx(act_q[P2_IDX]) * ys + cx(act_q[P3_IDX]);
        ny_d = cx(act_q[P4_IDX]) * xs + cx(act_q[P5_IDX]) * ys + cx(act_q[P6_IDX]);
        d_d  = cx(act_q[P7_IDX]) * xs + cx(act_q[P8_IDX]) * ys + cx(act_q[P9_IDX]);
        ab_x = nx_q[ACC_W-1] ? unsigned'(-nx_q) : unsigned'(nx_q);
        ab_y = ny_q[ACC_W-1] ? unsigned'(-ny_q) : unsigned'(ny_q);
        ab_d = d_q[ACC_W-1] ? unsigned'(-d_q) : unsigned'(d_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= 1'b0;
            for (int i = 0; i < N_COEF; i++) begin
                shd_q[i] <= ident(i);
                act_q[i] <= ident(i);
            end
            x_q   <= '0;
            y_q   <= '0;
            nx_q  <= '0;
            ny_q  <= '0;
            d_q   <= '0;
            sx_q  <= 1'b0;
            sy_q  <= 1'b0;
            ovx_q <= 1'b0;
            ovy_q <= 1'b0;
            dz_q  <= 1'b0;
        end else begin
            pend_q <= (pend_q && !copy) || coef_commit;
            if (coef_we && coef_addr < 4'(N_COEF))
                shd_q[coef_addr] <= coef_data;
            if (copy)
                act_q <= shd_q;
            if (accept) begin
                x_q <= x;
                y_q <= y;
            end
            if (state_q == MUL) begin
                nx_q <= nx_d;
                ny_q <= ny_d;
                d_q  <= d_d;
            end
            if (state_q == SIGN) begin
                sx_q  <= nx_q[ACC_W-1] ^ d_q[ACC_W-1];
                sy_q  <= ny_q[ACC_W-1] ^ d_q[ACC_W-1];
                ovx_q <= {{Q_W{1'b0}}, ab_x} >= {ab_d, {Q_W{1'b0}}};
                ovy_q <= {{Q_W{1'b0}}, ab_y} >= {ab_d, {Q_W{1'b0}}};
                dz_q  <= d_q == '0;
            end
        end
    end

    pixel_map_div #(.ACC_W(ACC_W), .Q_W(Q_W)) u_div_x (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .dividend (ab_x),
        .divisor  (ab_d),
        .quotient (qx),
        .done     (done_x)
    );

    pixel_map_div #(.ACC_W(ACC_W), .Q_W(Q_W)) u_div_y (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .dividend (ab_y),
        .divisor  (ab_d),
        .quotient (qy),
        .done     (done_y)
    );

    // A zero magnitude is in range even when the sign bit says negative.
    always_comb begin
        neg_x = sx_q && qx != '0;
        neg_y = sy_q && qy != '0;
        big_x = ovx_q || |qx[Q_W-1:OX_W];
        big_y = ovy_q || |qy[Q_W-1:OY_W];
        oob_v = dz_q || neg_x || big_x || neg_y || big_y;
`ifdef HMAP_CLAMP_EN
        vx = (dz_q || neg_x) ? '0 : big_x ? '1 : qx[OX_W-1:0];
        vy = (dz_q || neg_y) ? '0 : big_y ? '1 : qy[OY_W-1:0];
`else
        vx = oob_v ? '0 : qx[OX_W-1:0];
        vy = oob_v ? '0 : qy[OY_W-1:0];
`endif
        ox  = out_valid ? vx : '0;
        oy  = out_valid ? vy : '0;
        oob = out_valid && oob_v;
    end

endmodule

// File: tb/tb_pixel_map_stream.sv
// tb_pixel_map_stream: scoreboard bench for pixel_map_stream; a longint model predicts each result.
module tb_pixel_map_stream;

    localparam int P_W = 28;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  coef_we = 1'b0;
    logic [3:0]            coef_addr = '0;
    logic signed [P_W-1:0] coef_data = '0;
    logic                  coef_commit = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [9:0]            x = '0;
    logic [8:0]            y = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [9:0]            ox;
    logic [8:0]            oy;
    logic                  oob;

    typedef struct {
        longint ox;
        longint oy;
        longint oob;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    longint shd[9];
    longint act[9];

    pixel_map_stream dut (
        .clock       (clock),
        .reset       (reset),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .coef_commit (coef_commit),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x           (x),
        .y           (y),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ox          (ox),
        .oy          (oy),
        .oob         (oob)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin : mon
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ox", ox, e.ox);
                chk("oy", oy, e.oy);
                chk("oob", oob, e.oob);
            end
        end
    end

    function automatic exp_t model(input int xi, input int yi);
        exp_t   e;
        longint nx, ny, d, qx, qy;
        bit     okx, oky;
        nx = act[0] * xi + act[1] * yi + act[2];
        ny = act[3] * xi + act[4] * yi + act[5];
        d  = act[6] * xi + act[7] * yi + act[8];
        if (d == 0) begin
            e.ox = 0; e.oy = 0; e.oob = 1;
            return e;
        end
        qx  = nx / d;
        qy  = ny / d;
        okx = qx >= 0 && qx <= 1023;
        oky = qy >= 0 && qy <= 511;
        e.oob = (okx && oky) ? 0 : 1;
`ifdef HMAP_CLAMP_EN
        e.ox = qx < 0 ? 0 : qx > 1023 ? 1023 : qx;
        e.oy = qy < 0 ? 0 : qy > 511 ? 511 : qy;
`else
        e.ox = e.oob != 0 ? 0 : qx;
        e.oy = e.oob != 0 ? 0 : qy;
`endif
        return e;
    endfunction

    task automatic set_ident();
        for (int i = 0; i < 9; i++) begin
            shd[i] = (i == 0 || i == 4 || i == 8) ? 1 : 0;
            act[i] = shd[i];
        end
    endtask

    task automatic wr(input int a, input longint v);
        coef_we = 1'b1; coef_addr = 4'(a); coef_data = P_W'(v);
        @(posedge clock); #1;
        coef_we = 1'b0;
        shd[a] = v;
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        @(posedge clock); #1;
        coef_commit = 1'b0;
        @(posedge clock); #1;
        act = shd;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    // Caller sits #1 after a posedge in IDLE; the pixel is accepted at the next edge (cycle 0).
    task automatic send(input int xi, input int yi, input int lat, input int hold, input bit cm);
        int   n;
        exp_t e;
        e = model(xi, yi);
        sb.push_back(e);
        out_ready = (hold == 0);
        x = 10'(xi); y = 9'(yi); in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        n = 1;
        chk("busy_ready", in_ready, 0);
        while (!out_valid && n < 40) begin
            coef_commit = cm && n == 5;
            @(posedge clock); #1;
            n++;
        end
        coef_commit = 1'b0;
        chk("latency", n, lat);
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_ox", ox, e.ox);
            chk("hold_oy", oy, e.oy);
            chk("hold_oob", oob, e.oob);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        chk("ret_valid", out_valid, 0);
        chk("ret_ready", in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int seen;
        longint tp[9] = '{-35940, -43780, 420000, -33312, 10116, 252000, -612, -724, 8400};
        set_ident();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_ox", ox, 0);
        chk("rst_oy", oy, 0);
        chk("rst_oob", oob, 0);

        send(7, 3, 14, 0, 0);

        for (int i = 0; i < 9; i++) wr(i, tp[i]);
        commit();
        send(0, 0, 14, 0, 0);
        idle(2);
        send(100, 0, 14, 0, 0);

        wr(8, 0);
        commit();
        send(0, 0, 3, 0, 0);

        // New p9 only in shadow; commit lands during DIV, first IDLE accept still sees old bank.
        wr(8, 8400);
        send(100, 0, 14, 5, 1);
        send(0, 0, 3, 0, 0);
        idle(1);
        act = shd;
        send(100, 0, 14, 0, 0);

        x = 10'd9; y = 9'd9; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        idle(5);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        set_ident();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            seen += int'(out_valid);
            @(posedge clock); #1;
        end
        chk("mid_rst_silent", seen, 0);
        send(500, 200, 14, 0, 0);

        wr(2, -10);
        commit();
        send(5, 0, 14, 0, 0);
        wr(2, 0);
        wr(0, 3);
        commit();
        send(341, 0, 14, 0, 0);
        send(342, 0, 14, 0, 0);
        wr(0, 67108864);
        commit();
        send(1000, 0, 14, 0, 0);

        idle(3);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
